// File: rtl/uno_card_pile.sv
// Draw/discard pile manager for the UNO engine: load, LFSR-driven Fisher-Yates shuffle, streamed
// deal, and recycling of the discard pile (all but its top card) when the draw pile runs dry.
module uno_card_pile #(
   parameter int unsigned       CARD_W   = 6,
   parameter int unsigned       DEPTH    = 108,
   parameter int unsigned       MAX_DRAW = 4,
   parameter int unsigned       LFSR_W   = 16,
   parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
   localparam int unsigned      IDX_W    = $clog2(DEPTH + 1),
   localparam int unsigned      NUM_W    = $clog2(MAX_DRAW + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_load_valid,
   input  logic [CARD_W-1:0] i_load_card,
   input  logic              i_shuffle,
   input  logic              i_draw_valid,
   input  logic [NUM_W-1:0]  i_draw_num,
   input  logic              i_discard_valid,
   input  logic [CARD_W-1:0] i_discard_card,
   output logic              o_ready,
   output logic              o_card_valid,
   output logic [CARD_W-1:0] o_card,
   input  logic              i_card_ready,
   output logic [IDX_W-1:0]  o_draw_cnt,
   output logic [IDX_W-1:0]  o_disc_cnt,
   output logic [CARD_W-1:0] o_top_card,
   output logic              o_err
);

   localparam logic [IDX_W-1:0] DepthCnt   = IDX_W'(DEPTH);
   localparam logic [NUM_W-1:0] MaxDrawNum = NUM_W'(MAX_DRAW);

   typedef enum logic [1:0] {StIdle, StShuffle, StDeal, StRecycle} state_e;

   state_e            r_state, w_state_d;
   logic              r_ret_deal, w_ret_deal_d;
   logic [IDX_W-1:0]  r_draw_cnt, w_draw_cnt_d;
   logic [IDX_W-1:0]  r_disc_cnt, w_disc_cnt_d;
   logic [IDX_W-1:0]  r_idx, w_idx_d;
   logic [NUM_W-1:0]  r_rem, w_rem_d;
   logic [LFSR_W-1:0] r_lfsr, w_lfsr_d;
   logic [LFSR_W-1:0] r_ctr;
   logic              r_card_valid, w_card_valid_d;
   logic [CARD_W-1:0] r_card, w_card_d;
   logic              r_err, w_err_d;

   logic [CARD_W-1:0] r_draw [DEPTH];
   logic [CARD_W-1:0] r_disc [DEPTH];

   // Two draw-pile write ports so a shuffle swap completes in one cycle.
   logic              w_da_we, w_db_we, w_dc_we;
   logic [IDX_W-1:0]  w_da_addr, w_db_addr, w_dc_addr;
   logic [CARD_W-1:0] w_da_data, w_db_data, w_dc_data;

   logic              w_fb;
   logic [LFSR_W-1:0] w_lfsr_step, w_lfsr_mix, w_lfsr_entry;
   logic [IDX_W-1:0]  w_rand, w_draw_top, w_draw_below, w_disc_top;
   logic              w_draw_full, w_disc_full, w_num_bad;

   assign w_fb         = r_lfsr[LFSR_W-1] ^ r_lfsr[LFSR_W-3] ^ r_lfsr[LFSR_W-4] ^ r_lfsr[LFSR_W-6];
   assign w_lfsr_step  = {r_lfsr[LFSR_W-2:0], w_fb};
   assign w_lfsr_mix   = w_lfsr_step ^ r_ctr;
   assign w_lfsr_entry = (w_lfsr_mix == '0) ? SEED : w_lfsr_mix;
   assign w_rand       = r_lfsr[IDX_W-1:0];
   assign w_draw_top   = r_draw_cnt - IDX_W'(1);
   assign w_draw_below = r_draw_cnt - IDX_W'(2);
   assign w_disc_top   = r_disc_cnt - IDX_W'(1);
   assign w_draw_full  = (r_draw_cnt == DepthCnt);
   assign w_disc_full  = (r_disc_cnt == DepthCnt);
   assign w_num_bad    = (i_draw_num == '0) || (i_draw_num > MaxDrawNum);

   always_comb begin
      w_state_d      = r_state;
      w_ret_deal_d   = r_ret_deal;
      w_draw_cnt_d   = r_draw_cnt;
      w_disc_cnt_d   = r_disc_cnt;
      w_idx_d        = r_idx;
      w_rem_d        = r_rem;
      w_lfsr_d       = w_lfsr_step;
      w_card_valid_d = r_card_valid;
      w_card_d       = r_card;
      w_err_d        = 1'b0;
      w_da_we        = 1'b0;
      w_da_addr      = '0;
      w_da_data      = '0;
      w_db_we        = 1'b0;
      w_db_addr      = '0;
      w_db_data      = '0;
      w_dc_we        = 1'b0;
      w_dc_addr      = '0;
      w_dc_data      = '0;

      unique case (r_state)
         StIdle: begin
            if (i_clear) begin
               w_draw_cnt_d = '0;
               w_disc_cnt_d = '0;
            end else if (i_load_valid) begin
               if (w_draw_full) begin
                  w_err_d = 1'b1;
               end else begin
                  w_da_we      = 1'b1;
                  w_da_addr    = r_draw_cnt;
                  w_da_data    = i_load_card;
                  w_draw_cnt_d = r_draw_cnt + IDX_W'(1);
               end
            end else if (i_discard_valid) begin
               if (w_disc_full) begin
                  w_err_d = 1'b1;
               end else begin
                  w_dc_we      = 1'b1;
                  w_dc_addr    = r_disc_cnt;
                  w_dc_data    = i_discard_card;
                  w_disc_cnt_d = r_disc_cnt + IDX_W'(1);
               end
            end else if (i_shuffle) begin
               w_state_d    = StShuffle;
               w_ret_deal_d = 1'b0;
               w_idx_d      = w_draw_top;
               w_lfsr_d     = w_lfsr_entry;
            end else if (i_draw_valid) begin
               if (w_num_bad) begin
                  w_err_d = 1'b1;
               end else begin
                  w_state_d      = StDeal;
                  w_rem_d        = i_draw_num;
                  w_card_valid_d = 1'b0;
               end
            end
         end

         StShuffle: begin
            if ((r_draw_cnt < IDX_W'(2)) || (r_idx == '0)) begin
               w_state_d = r_ret_deal ? StDeal : StIdle;
            end else if (w_rand <= r_idx) begin
               w_da_we   = 1'b1;
               w_da_addr = r_idx;
               w_da_data = r_draw[w_rand];
               w_db_we   = 1'b1;
               w_db_addr = w_rand;
               w_db_data = r_draw[r_idx];
               w_idx_d   = r_idx - IDX_W'(1);
            end
         end

         StDeal: begin
            if (r_card_valid) begin
               if (i_card_ready) begin
                  w_draw_cnt_d = w_draw_top;
                  w_rem_d      = r_rem - NUM_W'(1);
                  if (r_rem == NUM_W'(1)) begin
                     w_card_valid_d = 1'b0;
                     w_state_d      = StIdle;
                  end else if (r_draw_cnt >= IDX_W'(2)) begin
                     w_card_d = r_draw[w_draw_below];
                  end else begin
                     w_card_valid_d = 1'b0;
                  end
               end
            end else if (r_rem == '0) begin
               w_state_d = StIdle;
            end else if (r_draw_cnt != '0) begin
               w_card_valid_d = 1'b1;
               w_card_d       = r_draw[w_draw_top];
            end else if (r_disc_cnt >= IDX_W'(2)) begin
               w_state_d = StRecycle;
               w_idx_d   = '0;
            end else begin
               // Starved with nothing worth recycling: drop the rest of the request.
               w_err_d   = 1'b1;
               w_rem_d   = '0;
               w_state_d = StIdle;
            end
         end

         StRecycle: begin
            if (r_idx < w_disc_top) begin
               w_da_we      = 1'b1;
               w_da_addr    = r_idx;
               w_da_data    = r_disc[r_idx];
               w_draw_cnt_d = r_idx + IDX_W'(1);
               w_idx_d      = r_idx + IDX_W'(1);
            end else begin
               w_dc_we      = 1'b1;
               w_dc_addr    = '0;
               w_dc_data    = r_disc[w_disc_top];
               w_disc_cnt_d = IDX_W'(1);
               w_state_d    = StShuffle;
               w_ret_deal_d = 1'b1;
               w_idx_d      = w_draw_top;
               w_lfsr_d     = w_lfsr_entry;
            end
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_ret_deal   <= 1'b0;
         r_draw_cnt   <= '0;
         r_disc_cnt   <= '0;
         r_idx        <= '0;
         r_rem        <= '0;
         r_lfsr       <= SEED;
         r_ctr        <= '0;
         r_card_valid <= 1'b0;
         r_card       <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_ret_deal   <= w_ret_deal_d;
         r_draw_cnt   <= w_draw_cnt_d;
         r_disc_cnt   <= w_disc_cnt_d;
         r_idx        <= w_idx_d;
         r_rem        <= w_rem_d;
         r_lfsr       <= w_lfsr_d;
         r_ctr        <= r_ctr + LFSR_W'(1);
         r_card_valid <= w_card_valid_d;
         r_card       <= w_card_d;
         r_err        <= w_err_d;
      end
   end

   // Pile storage carries no reset; the counts alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_da_we) r_draw[w_da_addr] <= w_da_data;
      if (w_db_we) r_draw[w_db_addr] <= w_db_data;
      if (w_dc_we) r_disc[w_dc_addr] <= w_dc_data;
   end

   assign o_ready      = (r_state == StIdle);
   assign o_card_valid = r_card_valid;
   assign o_card       = r_card;
   assign o_draw_cnt   = r_draw_cnt;
   assign o_disc_cnt   = r_disc_cnt;
   assign o_top_card   = (r_disc_cnt == '0) ? '0 : r_disc[w_disc_top];
   assign o_err        = r_err;

endmodule

// File: tb/tb_uno_card_pile.sv
// Bench for uno_card_pile: directed scenarios plus a randomized command mix, checked against a
// queue model of both piles that tracks how many top cards have a known order.
module tb_uno_card_pile;

   localparam int unsigned CARD_W   = 7;
   localparam int unsigned DEPTH    = 108;
   localparam int unsigned MAX_DRAW = 4;
   localparam int unsigned LFSR_W   = 16;
   localparam int unsigned IDX_W    = 7;
   localparam int unsigned NUM_W    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              load_valid = 1'b0;
   logic [CARD_W-1:0] load_card = '0;
   logic              shuffle = 1'b0;
   logic              draw_valid = 1'b0;
   logic [NUM_W-1:0]  draw_num = '0;
   logic              discard_valid = 1'b0;
   logic [CARD_W-1:0] discard_card = '0;
   logic              card_ready = 1'b0;
   logic              ready;
   logic              card_valid;
   logic [CARD_W-1:0] card;
   logic [IDX_W-1:0]  draw_cnt;
   logic [IDX_W-1:0]  disc_cnt;
   logic [CARD_W-1:0] top_card;
   logic              err;

   uno_card_pile #(
      .CARD_W  (CARD_W),
      .DEPTH   (DEPTH),
      .MAX_DRAW(MAX_DRAW),
      .LFSR_W  (LFSR_W),
      .SEED    (16'hACE1)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_clear        (clear),
      .i_load_valid   (load_valid),
      .i_load_card    (load_card),
      .i_shuffle      (shuffle),
      .i_draw_valid   (draw_valid),
      .i_draw_num     (draw_num),
      .i_discard_valid(discard_valid),
      .i_discard_card (discard_card),
      .o_ready        (ready),
      .o_card_valid   (card_valid),
      .o_card         (card),
      .i_card_ready   (card_ready),
      .o_draw_cnt     (draw_cnt),
      .o_disc_cnt     (disc_cnt),
      .o_top_card     (top_card),
      .o_err          (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   logic [CARD_W-1:0] m_draw[$];
   logic [CARD_W-1:0] m_disc[$];
   int m_known = 0;
   logic [CARD_W-1:0] dealt[$];

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: observed no finish, required finish within cycle budget");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CARD_W-1:0] m_top();
      if (m_disc.size() == 0) return '0;
      return m_disc[$];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_piles(input string tag);
      check({tag, "_draw_cnt"}, 32'(draw_cnt), m_draw.size());
      check({tag, "_disc_cnt"}, 32'(disc_cnt), m_disc.size());
      check({tag, "_top"}, 32'(top_card), 32'(m_top()));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready), 1);
      check({tag, "_valid"}, 32'(card_valid), 0);
      check({tag, "_card"}, 32'(card), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_draw_cnt"}, 32'(draw_cnt), 0);
      check({tag, "_disc_cnt"}, 32'(disc_cnt), 0);
      check({tag, "_top"}, 32'(top_card), 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_draw.delete();
      m_disc.delete();
      m_known = 0;
      check("clear_err", 32'(err), 0);
      check_piles("clear");
   endtask

   task automatic do_load(input logic [CARD_W-1:0] c);
      int full;
      full = (m_draw.size() == DEPTH) ? 1 : 0;
      load_valid = 1'b1;
      load_card  = c;
      tick();
      load_valid = 1'b0;
      check("load_err", 32'(err), full);
      if (full == 0) begin
         m_draw.push_back(c);
         m_known++;
      end
      check_piles("load");
   endtask

   task automatic do_discard(input logic [CARD_W-1:0] c);
      int full;
      full = (m_disc.size() == DEPTH) ? 1 : 0;
      discard_valid = 1'b1;
      discard_card  = c;
      tick();
      discard_valid = 1'b0;
      check("disc_err", 32'(err), full);
      if (full == 0) m_disc.push_back(c);
      check_piles("disc");
   endtask

   task automatic do_shuffle();
      shuffle = 1'b1;
      tick();
      shuffle = 1'b0;
      check("shuf_busy", 32'(ready), 0);
      for (int c = 0; c < 20000 && !ready; c++) tick();
      check("shuf_done", 32'(ready), 1);
      check("shuf_err", 32'(err), 0);
      m_known = 0;
      check_piles("shuf");
   endtask

   // Model side of one handshake: recycle lazily, then match the dealt card.
   task automatic take(input logic [CARD_W-1:0] c);
      int pos;
      logic [CARD_W-1:0] top;
      dealt.push_back(c);
      if (m_draw.size() == 0 && m_disc.size() >= 2) begin
         top = m_disc[$];
         for (int k = 0; k < m_disc.size() - 1; k++) m_draw.push_back(m_disc[k]);
         m_disc.delete();
         m_disc.push_back(top);
         m_known = 0;
      end
      if (m_draw.size() == 0) begin
         check("extra_card", 32'(card_valid), 0);
         return;
      end
      if (m_known > 0) begin
         check("card_lifo", 32'(c), 32'(m_draw[$]));
         void'(m_draw.pop_back());
         m_known--;
      end else begin
         pos = -1;
         foreach (m_draw[k]) if (pos < 0 && m_draw[k] == c) pos = k;
         check("card_member", (pos >= 0) ? 1 : 0, 1);
         if (pos >= 0) m_draw.delete(pos);
      end
   endtask

   task automatic do_draw(input int num, input int hold, output int got);
      int avail, dsz, exp_got, exp_err, held;
      logic err_seen, valid_seen, stall, rdy;
      logic [CARD_W-1:0] held_card;
      got = 0;
      draw_valid = 1'b1;
      draw_num   = NUM_W'(num);
      tick();
      draw_valid = 1'b0;
      if (num < 1 || num > MAX_DRAW) begin
         check("badnum_err", 32'(err), 1);
         check("badnum_ready", 32'(ready), 1);
         check_piles("badnum");
         return;
      end
      avail = m_draw.size();
      dsz   = m_disc.size();
      if (num <= avail) begin
         exp_got = num;
         exp_err = 0;
      end else if (dsz >= 2) begin
         exp_got = (num < avail + dsz - 1) ? num : avail + dsz - 1;
         exp_err = (num > avail + dsz - 1) ? 1 : 0;
      end else begin
         exp_got = avail;
         exp_err = 1;
      end
      check("draw_busy", 32'(ready), 0);
      held = 0;
      err_seen = 1'b0;
      valid_seen = 1'b0;
      stall = 1'b0;
      held_card = '0;
      for (int c = 0; c < 6000 && !ready; c++) begin
         if (stall) begin
            check("hold_valid", 32'(card_valid), 1);
            check("hold_card", 32'(card), 32'(held_card));
         end
         err_seen   = err_seen | err;
         valid_seen = valid_seen | card_valid;
         if (held < hold) begin
            rdy = 1'b0;
            if (card_valid) held++;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         card_ready = rdy;
         if (card_valid && rdy) begin
            take(card);
            got++;
         end
         stall     = card_valid && !rdy;
         held_card = card;
         tick();
      end
      card_ready = 1'b0;
      err_seen   = err_seen | err;
      check("draw_done", 32'(ready), 1);
      check("draw_got", got, exp_got);
      check("draw_err", 32'(err_seen), exp_err);
      check("draw_valid_seen", 32'(valid_seen), (exp_got > 0) ? 1 : 0);
      check_piles("draw");
   endtask

   initial begin
      int got, r, seen[128];
      logic dup, same;
      logic [CARD_W-1:0] ca, cb, cc, cx;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      #2 rst_n = 1'b1;
      tick();
      check_reset_outputs("post_reset");

      // Full deck: unique codes, overflow, shuffle, then deal all singly.
      for (int i = 0; i < DEPTH; i++) do_load(CARD_W'(i));
      do_load(CARD_W'(7'h55));
      do_shuffle();
      dealt.delete();
      for (int i = 0; i < DEPTH; i++) do_draw(1, 0, got);
      foreach (seen[k]) seen[k] = 0;
      dup = 1'b0;
      foreach (dealt[k]) begin
         if (dealt[k] >= DEPTH || seen[dealt[k]] != 0) dup = 1'b1;
         seen[dealt[k]]++;
      end
      check("deck_size", dealt.size(), DEPTH);
      check("deck_unique", 32'(dup), 0);
      same = 1'b1;
      foreach (dealt[k]) if (int'(dealt[k]) != DEPTH - 1 - k) same = 1'b0;
      check("deck_shuffled", 32'(same), 0);

      // Unshuffled LIFO deal with a 3-cycle stall.
      do_clear();
      repeat (5) do_load(CARD_W'($urandom));
      do_draw(4, 3, got);

      // Recycle mid-request.
      do_clear();
      ca = 7'h11; cb = 7'h22; cc = 7'h33; cx = 7'h44;
      do_load(cx);
      do_discard(ca);
      do_discard(cb);
      do_discard(cc);
      dealt.delete();
      do_draw(3, 0, got);
      check("recyc_first", 32'(dealt[0]), 32'(cx));
      check("recyc_pair", (({dealt[1], dealt[2]} == {ca, cb}) ||
                           ({dealt[1], dealt[2]} == {cb, ca})) ? 1 : 0, 1);
      check("recyc_top", 32'(top_card), 32'(cc));

      // Starved with a single discard, then illegal counts.
      do_draw(2, 0, got);
      do_draw(0, 0, got);
      do_draw(5, 0, got);
      do_draw(7, 0, got);

      // Discard overflow.
      do_clear();
      for (int i = 0; i < DEPTH; i++) do_discard(CARD_W'(i));
      do_discard(CARD_W'(7'h7f));

      // Command priority when several are raised together.
      do_load(CARD_W'(7'h05));
      {clear, load_valid, discard_valid, shuffle, draw_valid} = 5'b11111;
      load_card = 7'h01; discard_card = 7'h02; draw_num = 3'd1;
      tick();
      {clear, load_valid, discard_valid, shuffle, draw_valid} = 5'b00000;
      m_draw.delete(); m_disc.delete(); m_known = 0;
      check("prio_clear_ready", 32'(ready), 1);
      check_piles("prio_clear");
      {load_valid, discard_valid, shuffle, draw_valid} = 4'b1111;
      tick();
      {load_valid, discard_valid, shuffle, draw_valid} = 4'b0000;
      m_draw.push_back(7'h01); m_known++;
      check("prio_load_ready", 32'(ready), 1);
      check_piles("prio_load");
      {discard_valid, shuffle, draw_valid} = 3'b111;
      tick();
      {discard_valid, shuffle, draw_valid} = 3'b000;
      m_disc.push_back(7'h02);
      check("prio_disc_ready", 32'(ready), 1);
      check_piles("prio_disc");

      // Randomized command mix.
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if (r < 38) do_load(CARD_W'($urandom));
         else if (r < 62) do_discard(CARD_W'($urandom));
         else if (r < 86) do_draw($urandom_range(1, MAX_DRAW), $urandom_range(0, 2), got);
         else if (r < 94) do_shuffle();
         else if (r < 97) do_draw(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 7), 0, got);
         else do_clear();
      end

      // Reset during SHUFFLE.
      do_clear();
      for (int i = 0; i < 20; i++) do_load(CARD_W'($urandom));
      shuffle = 1'b1;
      tick();
      shuffle = 1'b0;
      tick();
      check("rst_shuf_busy", 32'(ready), 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_shuf");
      #2 rst_n = 1'b1;
      m_draw.delete(); m_disc.delete(); m_known = 0;
      tick();

      // Reset during DEAL with the card held.
      for (int i = 0; i < 5; i++) do_load(CARD_W'($urandom));
      draw_valid = 1'b1;
      draw_num   = 3'd3;
      tick();
      draw_valid = 1'b0;
      tick();
      check("rst_deal_valid", 32'(card_valid), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_deal");
      #2 rst_n = 1'b1;
      m_draw.delete(); m_disc.delete(); m_known = 0;
      tick();

      do_load(CARD_W'(7'h2a));
      do_draw(1, 0, got);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
